// File: rtl/adc_emu_pkg.sv
// Shared types and constants for the ADC emulator.
package adc_emu_pkg;

    localparam int unsigned DefaultDataW = 12;
    localparam int unsigned LfsrW        = 12;

    // Fibonacci taps for x^12 + x^6 + x^4 + x + 1; bit i carries the x^(i+1) term.
    localparam logic [LfsrW-1:0] LfsrTapMask = 12'h829;

    typedef enum logic [1:0] {
        ModeRamp  = 2'd0,
        ModeLfsr  = 2'd1,
        ModeConst = 2'd2
    } adc_mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StBurst,
        StGuard
    } adc_emu_state_e;

    // Raw mode code 3 is not a distinct generator; it behaves as ramp.
    function automatic adc_mode_e decode_mode(input logic [1:0] raw);
        adc_mode_e m;
        case (raw)
            2'd1:    m = ModeLfsr;
            2'd2:    m = ModeConst;
            default: m = ModeRamp;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/adc_sample_gen.sv
// Sample source for the ADC emulator: ramp accumulator, LFSR and output mux.
// sample_o is the value the next step will emit; the step advances the
// selected generator only, so the other one keeps its position.
module adc_sample_gen
    import adc_emu_pkg::*;
#(
    parameter int unsigned       DATA_W    = DefaultDataW,
    parameter logic [LfsrW-1:0]  LFSR_SEED = 12'hACE
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              step_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] const_i,
    output logic [DATA_W-1:0] sample_o
);

    logic [DATA_W-1:0] ramp_q, ramp_d;
    logic [LfsrW-1:0]  lfsr_q, lfsr_d;

    // Advance the active generator once per emitted sample.
    always_comb begin
        ramp_d = ramp_q;
        lfsr_d = lfsr_q;
        if (step_i) begin
            if (mode_i == ModeLfsr) begin
                lfsr_d = {lfsr_q[LfsrW-2:0], ^(lfsr_q & LfsrTapMask)};
            end else if (mode_i != ModeConst) begin
                ramp_d = ramp_q + DATA_W'(1);
            end
        end
    end

    // Generator state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ramp_q <= '0;
            lfsr_q <= LFSR_SEED;
        end else begin
            ramp_q <= ramp_d;
            lfsr_q <= lfsr_d;
        end
    end

    // Select the sample presented for the next step.
    always_comb begin
        sample_o = ramp_q;
        if (mode_i == ModeLfsr) begin
            sample_o = DATA_W'(lfsr_q);
        end else if (mode_i == ModeConst) begin
            sample_o = const_i;
        end
    end

endmodule

// File: rtl/adc_emulator.sv
// Behavioural ADC stand-in: answers a request edge with a fixed conversion
// delay, a burst of qualified samples, then a guard gap before re-arming.
module adc_emulator
    import adc_emu_pkg::*;
#(
    parameter int unsigned DATA_W       = DefaultDataW,
    parameter int unsigned CONV_CYCLES  = 10,
    parameter int unsigned BURST_LEN    = 8,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter logic [11:0] LFSR_SEED    = 12'hACE
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              adc_data_req_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] const_i,
    output logic              adc_data_rdy_o,
    output logic [DATA_W-1:0] adc_data_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic [15:0]       burst_cnt_o
);

    // Counters are loaded with N-1 and the state exits when they reach zero.
    localparam logic [7:0] ConvLoad  = 8'(CONV_CYCLES - 1);
    localparam logic [7:0] BurstLoad = 8'(BURST_LEN - 1);
    localparam logic [7:0] GuardLoad = (GUARD_CYCLES == 0) ? 8'd0 : 8'(GUARD_CYCLES - 1);

    adc_emu_state_e    state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              req_q;
    adc_mode_e         mode_q, mode_d;
    logic [DATA_W-1:0] const_q, const_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       burst_cnt_q, burst_cnt_d;
    logic              req_det;
    logic              step_en;
    logic [DATA_W-1:0] sample;

    adc_sample_gen #(
        .DATA_W    (DATA_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_sample_gen (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .step_i   (step_en),
        .mode_i   (mode_q),
        .const_i  (const_q),
        .sample_o (sample)
    );

    // Next-state logic: request handling, phase counters, sample stepping.
    always_comb begin
        req_det     = adc_data_req_i & ~req_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        const_d     = const_q;
        burst_cnt_d = burst_cnt_q;
        step_en     = 1'b0;
        // Any request edge outside IDLE is dropped and flagged.
        overrun_d   = req_det && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (req_det) begin
                    mode_d  = decode_mode(mode_i);
                    const_d = const_i;
                    cnt_d   = ConvLoad;
                    state_d = StConvert;
                end
            end
            StConvert: begin
                if (cnt_q == 8'd0) begin
                    // First sample lands on the same edge the burst starts.
                    step_en = 1'b1;
                    cnt_d   = BurstLoad;
                    state_d = StBurst;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StBurst: begin
                if (cnt_q == 8'd0) begin
                    burst_cnt_d = burst_cnt_q + 16'd1;
                    if (GUARD_CYCLES == 0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = GuardLoad;
                        state_d = StGuard;
                    end
                end else begin
                    step_en = 1'b1;
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            StGuard: begin
                if (cnt_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        data_d = step_en ? sample : data_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            req_q       <= 1'b0;
            mode_q      <= ModeRamp;
            const_q     <= '0;
            data_q      <= '0;
            overrun_q   <= 1'b0;
            burst_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= adc_data_req_i;
            mode_q      <= mode_d;
            const_q     <= const_d;
            data_q      <= data_d;
            overrun_q   <= overrun_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign adc_data_rdy_o = (state_q == StBurst);
    assign busy_o         = (state_q != StIdle);
    assign adc_data_o     = data_q;
    assign overrun_o      = overrun_q;
    assign burst_cnt_o    = burst_cnt_q;

endmodule

// File: tb/tb_adc_emulator.sv
// Self-checking bench for adc_emulator: a timeline model checked every cycle,
// plus directed literal checks on captured traces.
module tb_adc_emulator;

    localparam int C = 10;
    localparam int L = 8;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        reset_v;
    logic        req_v;
    logic [1:0]  mode_v;
    logic [11:0] const_v;
    logic        rdy;
    logic [11:0] data;
    logic        busy;
    logic        ovr;
    logic [15:0] bcnt;

    always #5 clk = ~clk;

    adc_emulator #(
        .DATA_W       (12),
        .CONV_CYCLES  (C),
        .BURST_LEN    (L),
        .GUARD_CYCLES (G),
        .LFSR_SEED    (12'hACE)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_v),
        .adc_data_req_i (req_v),
        .mode_i         (mode_v),
        .const_i        (const_v),
        .adc_data_rdy_o (rdy),
        .adc_data_o     (data),
        .busy_o         (busy),
        .overrun_o      (ovr),
        .burst_cnt_o    (bcnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Fibonacci form of x^12 + x^6 + x^4 + x + 1: term x^e reads bit e-1,
    // the register shifts toward the MSB and the feedback enters at bit 0.
    function automatic logic [11:0] lfsr_step(input logic [11:0] s);
        int   exps[4] = '{12, 6, 4, 1};
        logic fb      = 1'b0;
        foreach (exps[i]) fb ^= s[exps[i]-1];
        return {s[10:0], fb};
    endfunction

    // ---------------- timeline model ----------------
    // An accepted request at edge a means: busy after edges a..a+C+L+G-1,
    // samples on edges a+C..a+C+L-1, count bump on edge a+C+L.
    int          edge_n = 0;
    int          m_a;
    bit          m_active;
    int          m_mode;
    logic [11:0] m_const;
    int          m_ramp;
    logic [11:0] m_lfsr;
    logic        m_prev_req;
    logic        exp_rdy, exp_busy, exp_ovr;
    logic [11:0] exp_data;
    logic [15:0] exp_cnt;

    initial begin
        bit req_edge;
        bit busy_before;
        m_active = 0; m_a = 0; m_mode = 0; m_const = '0;
        m_ramp = 0; m_lfsr = 12'hACE; m_prev_req = 1'b0;
        exp_rdy = 0; exp_busy = 0; exp_ovr = 0; exp_data = '0; exp_cnt = '0;
        forever begin
            @(posedge clk);
            edge_n++;
            if (reset_v) begin
                m_active = 0; m_ramp = 0; m_lfsr = 12'hACE; m_prev_req = 1'b0;
                exp_ovr = 0; exp_data = '0; exp_cnt = '0;
            end else begin
                req_edge    = req_v && !m_prev_req;
                m_prev_req  = req_v;
                busy_before = m_active && (edge_n - 1 >= m_a) && (edge_n - 1 <= m_a + C + L + G - 1);
                exp_ovr     = 1'b0;
                if (req_edge) begin
                    if (busy_before) begin
                        exp_ovr = 1'b1;
                    end else begin
                        m_active = 1;
                        m_a      = edge_n;
                        m_mode   = (mode_v == 2'd1) ? 1 : (mode_v == 2'd2) ? 2 : 0;
                        m_const  = const_v;
                    end
                end
                if (m_active && edge_n >= m_a + C && edge_n <= m_a + C + L - 1) begin
                    if (m_mode == 1) begin
                        exp_data = m_lfsr;
                        m_lfsr   = lfsr_step(m_lfsr);
                    end else if (m_mode == 2) begin
                        exp_data = m_const;
                    end else begin
                        exp_data = 12'(m_ramp);
                        m_ramp   = (m_ramp == 2047) ? -2048 : m_ramp + 1;
                    end
                end
                if (m_active && edge_n == m_a + C + L) exp_cnt = exp_cnt + 16'd1;
            end
            exp_rdy  = m_active && edge_n >= m_a + C && edge_n <= m_a + C + L - 1;
            exp_busy = m_active && edge_n >= m_a && edge_n <= m_a + C + L + G - 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk($sformatf("rdy@%0d", edge_n), 32'(rdy), 32'(exp_rdy));
                chk($sformatf("busy@%0d", edge_n), 32'(busy), 32'(exp_busy));
                chk($sformatf("overrun@%0d", edge_n), 32'(ovr), 32'(exp_ovr));
                chk($sformatf("data@%0d", edge_n), 32'(data), 32'(exp_data));
                chk($sformatf("burst_cnt@%0d", edge_n), 32'(bcnt), 32'(exp_cnt));
            end
        end
    end

    // ---------------- directed traces ----------------
    // Index k holds outputs after edge E0+k.
    logic        tr_rdy [64];
    logic        tr_busy[64];
    logic        tr_ovr [64];
    logic [11:0] tr_data[64];
    logic [15:0] tr_cnt [64];

    task automatic grab(input int k);
        tr_rdy[k] = rdy; tr_busy[k] = busy; tr_ovr[k] = ovr;
        tr_data[k] = data; tr_cnt[k] = bcnt;
    endtask

    // pat[k] is the request level seen at edge E0+k (pat[0] must be 1).
    task automatic trace(input logic [63:0] pat, input int n, input int chg_k,
                         input logic [11:0] cnew, input int rst_k);
        req_v = 1'b1;
        @(negedge clk);
        grab(0);
        for (int k = 1; k <= n; k++) begin
            req_v   = pat[k];
            reset_v = (k == rst_k);
            if (k == chg_k) begin
                const_v = cnew;
                mode_v  = 2'd1;
            end
            @(negedge clk);
            grab(k);
        end
        req_v   = 1'b0;
        reset_v = 1'b0;
    endtask

    task automatic apply_reset();
        reset_v = 1'b1;
        req_v   = 1'b0;
        repeat (2) @(negedge clk);
        reset_v = 1'b0;
        @(negedge clk);
    endtask

    logic [11:0] seq[16];
    int          cnt_a, cnt_b;

    initial begin
        reset_v = 1'b1; req_v = 1'b0; mode_v = 2'd0; const_v = '0;
        @(negedge clk);
        cmp_en = 1'b1;
        apply_reset();

        // Reset values.
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(ovr), 0);
        chk("rst_burst_cnt", 32'(bcnt), 0);

        // Single ramp burst from reset.
        mode_v = 2'd0;
        trace(64'h1, 22, -1, '0, -1);
        chk("t1_busy_e0", 32'(tr_busy[0]), 1);
        chk("t1_rdy_e9", 32'(tr_rdy[9]), 0);
        chk("t1_rdy_e10", 32'(tr_rdy[10]), 1);
        chk("t1_rdy_e17", 32'(tr_rdy[17]), 1);
        chk("t1_rdy_e18", 32'(tr_rdy[18]), 0);
        for (int i = 0; i < 8; i++) chk($sformatf("t1_data%0d", i), 32'(tr_data[10+i]), 32'(i));
        chk("t1_data_hold", 32'(tr_data[20]), 7);
        chk("t1_cnt_e17", 32'(tr_cnt[17]), 0);
        chk("t1_cnt_e18", 32'(tr_cnt[18]), 1);
        chk("t1_busy_e19", 32'(tr_busy[19]), 1);
        chk("t1_busy_e20", 32'(tr_busy[20]), 0);

        // Constant mode; const and mode change during CONVERT must not matter.
        mode_v = 2'd2; const_v = 12'h800;
        trace(64'h1, 20, 3, 12'h123, -1);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_const%0d", i), 32'($signed(tr_data[10+i])), -2048);

        // LFSR from reset, two bursts.
        apply_reset();
        mode_v = 2'd1;
        trace(64'h1, 20, -1, '0, -1);
        for (int i = 0; i < 8; i++) seq[i] = tr_data[10+i];
        trace(64'h1, 20, -1, '0, -1);
        for (int i = 0; i < 8; i++) seq[8+i] = tr_data[10+i];
        chk("t3_lfsr0", 32'(seq[0]), 32'h0ACE);
        chk("t3_lfsr1", 32'(seq[1]), 32'h059C);
        chk("t3_lfsr2", 32'(seq[2]), 32'h0B39);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 16; i++) begin
            if (seq[i] == 12'h000) cnt_a++;
            for (int j = i + 1; j < 16; j++) if (seq[i] == seq[j]) cnt_b++;
        end
        chk("t3_zeros", 32'(cnt_a), 0);
        chk("t3_repeats", 32'(cnt_b), 0);

        // Ramp wrap over 256 back-to-back bursts.
        apply_reset();
        mode_v = 2'd0;
        for (int b = 0; b < 256; b++) trace(64'h1, 20, -1, '0, -1);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t4_last%0d", i), 32'($signed(tr_data[10+i])), 32'(2040 + i));
        trace(64'h1, 20, -1, '0, -1);
        chk("t4_wrap_first", 32'($signed(tr_data[10])), -2048);
        chk("t4_wrap_second", 32'($signed(tr_data[11])), -2047);
        chk("t4_burst_cnt", 32'(tr_cnt[18]), 257);

        // Overrun pulses at E0+3 and E0+12, request held high through E0+24.
        trace(64'h0000_0000_01FF_F009, 30, -1, '0, -1);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k <= 30; k++) begin
            if (tr_ovr[k]) cnt_a++;
            if (tr_rdy[k]) cnt_b++;
        end
        chk("t5_ovr_e3", 32'(tr_ovr[3]), 1);
        chk("t5_ovr_e4", 32'(tr_ovr[4]), 0);
        chk("t5_ovr_e12", 32'(tr_ovr[12]), 1);
        chk("t5_ovr_total", 32'(cnt_a), 2);
        chk("t5_rdy_total", 32'(cnt_b), 8);
        chk("t5_idle_e20", 32'(tr_busy[20]), 0);
        chk("t5_idle_e25", 32'(tr_busy[25]), 0);
        trace(64'h1, 20, -1, '0, -1);
        chk("t5_new_accept", 32'(tr_busy[0]), 1);

        // Request on the burst-end edge is an overrun.
        trace(64'h0000_0000_0004_0001, 22, -1, '0, -1);
        chk("t5b_ovr_e18", 32'(tr_ovr[18]), 1);
        chk("t5b_no_conv", 32'(tr_busy[21]), 0);

        // Reset mid-burst, then ramp restarts from zero.
        trace(64'h1, 14, -1, '0, 13);
        chk("t6_pre_rdy", 32'(tr_rdy[12]), 1);
        chk("t6_rdy", 32'(tr_rdy[13]), 0);
        chk("t6_data", 32'(tr_data[13]), 0);
        chk("t6_busy", 32'(tr_busy[13]), 0);
        chk("t6_ovr", 32'(tr_ovr[13]), 0);
        chk("t6_cnt", 32'(tr_cnt[13]), 0);
        trace(64'h1, 20, -1, '0, -1);
        chk("t6_restart0", 32'(tr_data[10]), 0);
        chk("t6_restart1", 32'(tr_data[11]), 1);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_emulator.md
# adc_emulator

Synthesizable behavioural model of the ADC side of the sample-request interface. It answers a conversion request from the ADC-facing master (`adc_data_req`) with a fixed conversion delay, then a burst of `BURST_LEN` signed samples qualified by `adc_data_rdy`. It sits where the physical ADC would be, both in simulation and on hardware bring-up boards without a converter. Samples come from a ramp, an LFSR or a constant, so the downstream capture path can be checked bit-exactly.

## Interface
- `DATA_W`, 12, sample width, two's complement
- `CONV_CYCLES`, 10, clocks from accepted request to first ready cycle; legal range 1..255
- `BURST_LEN`, 8, ready-high cycles per conversion; legal range 1..255
- `GUARD_CYCLES`, 2, idle clocks forced after each burst before a new request is accepted; 0 allowed
- `LFSR_SEED`, 12'hACE, LFSR reset value; must be non-zero

- `clk_i`  in  1  single system clock
- `reset_i`  in  1  one clock; reset is synchronous and active-high
- `adc_data_req_i`  in  1  conversion request from the ADC master; rising edge is the request
- `mode_i`  in  2  0 ramp, 1 LFSR, 2 constant, 3 treated as ramp
- `const_i`  in  DATA_W  sample value in constant mode
- `adc_data_rdy_o`  out  1  high while `adc_data_o` carries a burst sample
- `adc_data_o`  out  DATA_W  signed sample
- `busy_o`  out  1  high in any state other than IDLE
- `overrun_o`  out  1  one-cycle pulse when a request is dropped
- `burst_cnt_o`  out  16  number of completed bursts; wraps

## Operation
- Reset values: `adc_data_rdy_o`=0, `adc_data_o`=0, `busy_o`=0, `overrun_o`=0, `burst_cnt_o`=0. Ramp accumulator = 0, LFSR = `LFSR_SEED`, state = IDLE, request edge register = 0.
- Request detection: `adc_data_req_i` is registered once. A request is present when the registered value is 0 and the current input is 1.
- States:
  - IDLE: on a request, latch `mode_i` and `const_i`, load the delay counter, go to CONVERT.
  - CONVERT: count `CONV_CYCLES` clocks, then go to BURST.
  - BURST: emit `BURST_LEN` samples. After the last one, increment `burst_cnt_o` and go to GUARD, or to IDLE if `GUARD_CYCLES`=0.
  - GUARD: count `GUARD_CYCLES` clocks, then go to IDLE.
- Overrun: a request detected in CONVERT, BURST or GUARD is dropped, `overrun_o` pulses for one clock, and the state is unaffected.
- Sample generation: one new sample per BURST cycle. There is no generator activity outside BURST.
  - Ramp: accumulator increments by 1 per sample and wraps from +2047 to −2048. It is continuous across bursts; only reset clears it.
  - LFSR: 12-bit Fibonacci, polynomial x^12+x^6+x^4+x+1, shifted once per sample. It never reaches zero.
  - Constant: the latched `const_i` on every sample.
- `adc_data_o` holds the last burst sample after the burst, until the next burst or reset.
- Mode and constant changes mid-conversion have no effect until the next accepted request.
- Reset asserted in any state: all outputs and state return to reset values on that edge. There is no partial burst completion.

## Timing
- Let edge E0 be the first edge where `adc_data_req_i`=1 after a 0, with the FSM in IDLE. E0 is the transition into CONVERT.
- `busy_o`=1 from E0. `adc_data_rdy_o` rises at edge E0+`CONV_CYCLES` and stays high exactly `BURST_LEN` clocks.
- `adc_data_o` updates on the same edge `adc_data_rdy_o` rises, and on every following edge while it is high. Each ready cycle therefore carries a distinct sample: ramp yields k, k+1, …
- `burst_cnt_o` increments on the edge `adc_data_rdy_o` falls.
- `busy_o` falls `GUARD_CYCLES` clocks after `adc_data_rdy_o` falls. With `GUARD_CYCLES`=0 they fall together.
- Back-to-back: the earliest accepted next request is at the edge where `busy_o` is already 0.
- Request and burst end on the same edge: the request counts as an overrun.
- `overrun_o` is asserted the clock after the offending edge and lasts 1 clock.

## Structure
- Package `adc_emu_pkg` holds:
  - mode enum `adc_mode_e` (RAMP, LFSR, CONST)
  - state enum `adc_emu_state_e` (IDLE, CONVERT, BURST, GUARD)
  - LFSR tap mask constant
  - default `DATA_W`
- One sub-module, `adc_sample_gen`, contains the ramp accumulator, LFSR and output mux. Its inputs are the step enable and the latched mode/const; its output is the next sample.
- The FSM, counters, edge detect and overrun logic live in `adc_emulator`.

## Test plan
- Reset release, mode 0, single request at E0: `adc_data_rdy_o` high at E0+10..E0+17. Data sequence 0,1,…,7. `burst_cnt_o`=1. `busy_o` low at E0+20.
- Mode 2, `const_i`=12'h800, request; `const_i` changed to 12'h123 during CONVERT: all 8 samples read −2048.
- Mode 1 from reset, two bursts: the 16 samples match the reference LFSR stepped from 12'hACE, with no repeats and no zero.
- Ramp wrap: 256 requests in mode 0 give a final sample sequence 2040..2047; the next burst starts at −2048. `burst_cnt_o`=257.
- Request pulses at E0+3 and E0+12, and `adc_data_req_i` held high through the burst: two `overrun_o` pulses, a single burst, no second conversion until a new 0→1 edge after `busy_o` falls.
- `reset_i` asserted at E0+13 mid-burst: at the next edge all outputs are 0 and the state is IDLE. A request after reset produces ramp samples starting again at 0.
